// File: rtl/sdr_proto_mon.sv
// SDRAM command-bus protocol monitor: per-bank ACT/PRE timing checks; violations reported one cycle after the command edge.
// Passive observer with no backpressure. Optional tRAS checking is compiled in with `define SDR_MON_TRAS_EN.
module sdr_proto_mon #(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int TRCD      = 3,
    parameter int TRP       = 3,
    parameter int TRAS      = 6
) (
    input  logic                 sdram_clk,
    input  logic                 sdram_resetn,
    input  logic                 sdr_cke,
    input  logic                 sdr_cs_n,
    input  logic                 sdr_ras_n,
    input  logic                 sdr_cas_n,
    input  logic                 sdr_we_n,
    input  logic [BA_W-1:0]      sdr_ba,
    input  logic [12:0]          sdr_addr,
    input  logic                 err_clr,
    output logic                 err_valid,
    output logic [2:0]           err_code,
    output logic [BA_W-1:0]      err_bank,
    output logic [NUM_BANKS-1:0] err_sticky,
    output logic [15:0]          err_count
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OPEN   = 2'd1;
    localparam logic [1:0] S_PRECHG = 2'd2;

    logic                 w_cmd_vld;
    logic [2:0]           w_rcw;
    logic                 w_act, w_rd, w_wr, w_pre, w_ref, w_lmr, w_bst;
    logic                 w_all, w_banked;
    logic [NUM_BANKS-1:0] w_tgt, w_idle, w_open, w_prechg, w_rcd_ok, w_ras_busy;
    logic                 w_v1, w_v2, w_v3, w_v4, w_v5;
    logic [BA_W-1:0]      w_b3, w_b4, w_b5;
    logic [2:0]           w_code;
    logic [BA_W-1:0]      w_bank;
    logic                 w_viol;
    logic [NUM_BANKS-1:0] w_bank_oh;
    logic                 w_unused;

    logic                 r_err_valid;
    logic [2:0]           r_err_code;
    logic [BA_W-1:0]      r_err_bank;
    logic [NUM_BANKS-1:0] r_err_sticky;
    logic [15:0]          r_err_count;

    assign w_cmd_vld = sdr_cke & ~sdr_cs_n;
    assign w_rcw     = {sdr_ras_n, sdr_cas_n, sdr_we_n};
    assign w_act     = w_cmd_vld & (w_rcw == 3'b011);
    assign w_rd      = w_cmd_vld & (w_rcw == 3'b101);
    assign w_wr      = w_cmd_vld & (w_rcw == 3'b100);
    assign w_pre     = w_cmd_vld & (w_rcw == 3'b010);
    assign w_ref     = w_cmd_vld & (w_rcw == 3'b001);
    assign w_lmr     = w_cmd_vld & (w_rcw == 3'b000);
    assign w_bst     = w_cmd_vld & (w_rcw == 3'b110);
    // Precharge-all, refresh and mode-register commands touch every bank
    assign w_all     = (w_pre & sdr_addr[10]) | w_ref | w_lmr;
    assign w_banked  = w_act | w_rd | w_wr | w_bst | w_pre;
    assign w_unused  = ^{sdr_addr[12:11], sdr_addr[9:0], 4'(TRAS)};

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic       w_sel;
        logic [1:0] r_state;
        logic [3:0] r_trcd;
        logic [3:0] r_trp;

        assign w_sel         = (sdr_ba == BA_W'(g));
        assign w_tgt[g]      = w_all | (w_banked & w_sel);
        assign w_idle[g]     = (r_state == S_IDLE);
        assign w_open[g]     = (r_state == S_OPEN);
        assign w_prechg[g]   = (r_state == S_PRECHG);
        assign w_rcd_ok[g]   = (r_trcd == 4'd0);

        always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
            if (!sdram_resetn) begin
                r_state <= S_IDLE;
                r_trcd  <= 4'd0;
                r_trp   <= 4'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_act && w_sel) begin
                            r_state <= S_OPEN;
                            r_trcd  <= 4'(TRCD - 1);
                        end
                    end
                    S_OPEN: begin
                        if (r_trcd != 4'd0) r_trcd <= r_trcd - 4'd1;
                        if (w_pre && (sdr_addr[10] || w_sel)) begin
                            r_state <= S_PRECHG;
                            r_trp   <= 4'(TRP - 1);
                        end
                    end
                    S_PRECHG: begin
                        if (r_trp != 4'd0) r_trp <= r_trp - 4'd1;
                        else if (!w_tgt[g]) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end

`ifdef SDR_MON_TRAS_EN
        logic [3:0] r_tras;
        always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
            if (!sdram_resetn) r_tras <= 4'd0;
            else if (w_idle[g] && w_act && w_sel) r_tras <= 4'(TRAS - 1);
            else if (w_open[g] && r_tras != 4'd0) r_tras <= r_tras - 4'd1;
        end
        assign w_ras_busy[g] = w_open[g] && (r_tras != 4'd0);
`else
        assign w_ras_busy[g] = 1'b0;
`endif
    end

    // Descending scan so the lowest offending bank is the one left standing
    always_comb begin
        w_v3 = 1'b0; w_b3 = '0;
        w_v4 = 1'b0; w_b4 = '0;
        w_v5 = 1'b0; w_b5 = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (w_pre && (sdr_addr[10] || sdr_ba == BA_W'(b)) && w_ras_busy[b]) begin
                w_v3 = 1'b1; w_b3 = BA_W'(b);
            end
            if ((w_ref || w_lmr) && !w_idle[b]) begin
                w_v4 = 1'b1; w_b4 = BA_W'(b);
            end
            if (w_tgt[b] && w_prechg[b]) begin
                w_v5 = 1'b1; w_b5 = BA_W'(b);
            end
        end
    end

    assign w_v1 = w_act && !w_idle[sdr_ba];
    assign w_v2 = (w_rd || w_wr) && !(w_open[sdr_ba] && w_rcd_ok[sdr_ba]);

    always_comb begin
        w_code = 3'd0;
        w_bank = '0;
        if (w_v1)      begin w_code = 3'd1; w_bank = sdr_ba; end
        else if (w_v2) begin w_code = 3'd2; w_bank = sdr_ba; end
        else if (w_v3) begin w_code = 3'd3; w_bank = w_b3;   end
        else if (w_v4) begin w_code = 3'd4; w_bank = w_b4;   end
        else if (w_v5) begin w_code = 3'd5; w_bank = w_b5;   end
    end

    assign w_viol    = (w_code != 3'd0);
    assign w_bank_oh = w_viol ? (NUM_BANKS'(1) << w_bank) : '0;

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            r_err_valid  <= 1'b0;
            r_err_code   <= 3'd0;
            r_err_bank   <= '0;
            r_err_sticky <= '0;
            r_err_count  <= 16'd0;
        end else begin
            r_err_valid  <= w_viol;
            r_err_code   <= w_code;
            r_err_bank   <= w_bank;
            r_err_sticky <= (err_clr ? '0 : r_err_sticky) | w_bank_oh;
            if (err_clr) r_err_count <= {15'd0, w_viol};
            else if (w_viol && r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_valid  = r_err_valid;
    assign err_code   = r_err_code;
    assign err_bank   = r_err_bank;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;
endmodule

// File: tb/tb_sdr_proto_mon.sv
// Bench for sdr_proto_mon: timestamp-based bank model compared every cycle, directed and random command streams.
module tb_sdr_proto_mon;
    localparam int NB = 4, BW = 2, TRCD = 3, TRP = 3, TRAS = 6;
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD  = 4'b0101, C_WR = 4'b0100,
                           C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000, C_BST = 4'b0110;
    localparam int IDLE = 0, OPEN = 1, PRECHG = 2;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1, clr = 1'b0;
    logic [BW-1:0] ba = '0;
    logic [12:0]   addr = '0;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [BW-1:0] err_bank;
    logic [NB-1:0] err_sticky;
    logic [15:0]   err_count;

    int checks = 0, errors = 0;
    bit cmp_en = 1'b0;

    sdr_proto_mon #(.NUM_BANKS(NB), .BA_W(BW), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS)) dut (
        .sdram_clk(clk), .sdram_resetn(rst_n), .sdr_cke(cke), .sdr_cs_n(cs_n),
        .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n), .sdr_ba(ba), .sdr_addr(addr),
        .err_clr(clr), .err_valid(err_valid), .err_code(err_code), .err_bank(err_bank),
        .err_sticky(err_sticky), .err_count(err_count));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: bank states with ACT/PRE timestamps instead of counters
    int            st[NB];
    longint        act_c[NB], pre_c[NB];
    longint        cyc = 0;
    logic          e_vld = 1'b0;
    logic [2:0]    e_code = 3'd0;
    logic [BW-1:0] e_bank = '0;
    logic [NB-1:0] e_sticky = '0;
    logic [15:0]   e_cnt = 16'd0;

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin st[b] = IDLE; act_c[b] = 0; pre_c[b] = 0; end
        cyc = 0; e_vld = 1'b0; e_code = 3'd0; e_bank = '0; e_sticky = '0; e_cnt = 16'd0;
    endtask

    task automatic model_step();
        bit is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst, v;
        bit tgt[NB];
        int nst[NB];
        int code, bank, b3, b4, b5, sb;
        v = cke && !cs_n;
        sb = int'(ba);
        is_act = v && {ras_n, cas_n, we_n} == 3'b011;
        is_rd  = v && {ras_n, cas_n, we_n} == 3'b101;
        is_wr  = v && {ras_n, cas_n, we_n} == 3'b100;
        is_pre = v && {ras_n, cas_n, we_n} == 3'b010;
        is_ref = v && {ras_n, cas_n, we_n} == 3'b001;
        is_lmr = v && {ras_n, cas_n, we_n} == 3'b000;
        is_bst = v && {ras_n, cas_n, we_n} == 3'b110;
        b3 = -1; b4 = -1; b5 = -1;
        for (int b = 0; b < NB; b++) begin
            tgt[b] = (is_pre && addr[10]) || is_ref || is_lmr ||
                     ((is_act || is_rd || is_wr || is_bst || is_pre) && sb == b);
`ifdef SDR_MON_TRAS_EN
            if (b3 < 0 && is_pre && (addr[10] || sb == b) && st[b] == OPEN && cyc - act_c[b] < TRAS) b3 = b;
`endif
            if (b4 < 0 && (is_ref || is_lmr) && st[b] != IDLE) b4 = b;
            if (b5 < 0 && tgt[b] && st[b] == PRECHG) b5 = b;
        end
        code = 0; bank = 0;
        if (is_act && st[sb] != IDLE) begin code = 1; bank = sb; end
        else if ((is_rd || is_wr) && !(st[sb] == OPEN && cyc - act_c[sb] >= TRCD)) begin code = 2; bank = sb; end
        else if (b3 >= 0) begin code = 3; bank = b3; end
        else if (b4 >= 0) begin code = 4; bank = b4; end
        else if (b5 >= 0) begin code = 5; bank = b5; end
        for (int b = 0; b < NB; b++) begin
            nst[b] = st[b];
            if (st[b] == IDLE && is_act && sb == b) begin nst[b] = OPEN; act_c[b] = cyc; end
            if (st[b] == OPEN && is_pre && (addr[10] || sb == b)) begin nst[b] = PRECHG; pre_c[b] = cyc; end
            if (st[b] == PRECHG && !tgt[b] && cyc - pre_c[b] >= TRP) nst[b] = IDLE;
        end
        for (int b = 0; b < NB; b++) st[b] = nst[b];
        cyc++;
        if (clr) begin e_sticky = '0; e_cnt = 16'd0; end
        if (code != 0) begin
            e_sticky[bank] = 1'b1;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
        e_vld = (code != 0); e_code = 3'(code); e_bank = BW'(bank);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc err_valid", err_valid, e_vld);
            chk("cyc err_code", err_code, e_code);
            chk("cyc err_bank", err_bank, e_bank);
            chk("cyc err_sticky", err_sticky, e_sticky);
            chk("cyc err_count", err_count, e_cnt);
        end
    end

    task automatic set_pins(input logic [3:0] c, input int b, input bit a10, input bit clr_i, input bit k);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba = BW'(b);
        addr = 13'($urandom);
        addr[10] = a10;
        clr = clr_i;
        cke = k;
    endtask

    task automatic issue(input logic [3:0] c, input int b, input bit a10 = 1'b0, input bit clr_i = 1'b0);
        @(negedge clk);
        set_pins(c, b, a10, clr_i, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        set_pins(C_NOP, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic lit(input string nm, input int code, input int bank);
        @(posedge clk);
        #1;
        chk({nm, " dut code"}, err_code, code);
        chk({nm, " dut bank"}, err_bank, bank);
        chk({nm, " dut valid"}, err_valid, code != 0);
        chk({nm, " model code"}, e_code, code);
    endtask

    initial begin
        int r;
        logic [3:0] c;
        #12;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("reset valid", err_valid, 0);
        chk("reset count", err_count, 0);
        chk("reset sticky", err_sticky, 0);
        cmp_en = 1'b1;

        // ACT->READ spacing at and below tRCD
        do_reset();
        issue(C_ACT, 0); issue(C_NOP, 0); issue(C_NOP, 0); issue(C_RD, 0);
        lit("rcd ok", 0, 0);
        do_reset();
        issue(C_ACT, 0); issue(C_NOP, 0); issue(C_RD, 0);
        lit("rcd early", 2, 0);

        // Double ACT
        do_reset();
        issue(C_ACT, 1); issue(C_NOP, 0); issue(C_ACT, 1);
        lit("double act", 1, 1);
        chk("double act sticky", err_sticky, 4'b0010);
        chk("double act count", err_count, 1);

        // Early PRE against tRAS
        do_reset();
        issue(C_ACT, 2); issue(C_NOP, 0); issue(C_NOP, 0); issue(C_PRE, 2);
`ifdef SDR_MON_TRAS_EN
        lit("early pre", 3, 2);
`else
        lit("early pre", 0, 0);
`endif

        // REF during precharge outranks the PRECHG violation
        do_reset();
        issue(C_ACT, 3); issue(C_PRE, 0, 1'b1); issue(C_REF, 0);
        lit("ref busy", 4, 3);

        // PRE to idle bank, PRE to precharging bank, return to IDLE after tRP
        do_reset();
        issue(C_PRE, 1);
        lit("pre idle", 0, 0);
        issue(C_ACT, 0);
        for (int i = 0; i < 6; i++) issue(C_NOP, 0);
        issue(C_PRE, 0);
        lit("pre open", 0, 0);
        issue(C_PRE, 0);
        lit("pre prechg", 5, 0);
        issue(C_NOP, 0); issue(C_NOP, 0); issue(C_ACT, 0);
        lit("act after trp", 0, 0);
        issue(C_WR, 1);
        lit("wr idle", 2, 1);

        // Count saturation, then clear coinciding with a violation
        do_reset();
        issue(C_ACT, 0);
        for (int i = 0; i < 65540; i++) issue(C_ACT, 0);
        @(posedge clk);
        #1;
        chk("sat count", err_count, 16'hFFFF);
        issue(C_ACT, 0, 1'b0, 1'b1);
        lit("clr+viol", 1, 0);
        chk("clr+viol count", err_count, 1);
        chk("clr+viol sticky", err_sticky, 4'b0001);

        // Asynchronous reset with bank 0 open
        do_reset();
        issue(C_ACT, 0); issue(C_ACT, 0);
        @(posedge clk);
        #2;
        set_pins(C_NOP, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async rst valid", err_valid, 0);
        chk("async rst code", err_code, 0);
        chk("async rst sticky", err_sticky, 0);
        chk("async rst count", err_count, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        issue(C_RD, 0);
        lit("rd after rst", 2, 0);

        // Random command stream
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 22)      c = C_ACT;
            else if (r < 34) c = C_RD;
            else if (r < 44) c = C_WR;
            else if (r < 62) c = C_PRE;
            else if (r < 84) c = C_NOP;
            else if (r < 87) c = C_REF;
            else if (r < 89) c = C_LMR;
            else if (r < 93) c = C_BST;
            else             c = {1'b1, 3'($urandom)};
            set_pins(c, $urandom_range(0, NB - 1), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 40) == 0, $urandom_range(0, 19) != 0);
            if (i == 2000) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
        end
        issue(C_NOP, 0);
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdr_proto_mon.md
SDR_PROTO_MON -- requirements
Module: sdr_proto_mon

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of SDRAM banks tracked (power of 2, 2..8).
REQ-002 SHALL have parameter BA_W, default 2, bank address width ($clog2(NUM_BANKS)).
REQ-003 SHALL have parameter TRCD, default 3, ACT to READ/WRITE minimum in clocks (1..15).
REQ-004 SHALL have parameter TRP, default 3, PRE to next command on that bank minimum in clocks (1..15).
REQ-005 SHALL have parameter TRAS, default 6, ACT to PRE minimum in clocks (1..15).
REQ-006 SHALL have port sdram_clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port sdram_resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, each input, 1, SDRAM command pins.
REQ-009 SHALL have port sdr_ba, input, BA_W, bank address.
REQ-010 SHALL have port sdr_addr, input, 13; only bit 10 (precharge-all) is used.
REQ-011 SHALL have port err_clr, input, 1, synchronous clear of sticky status and count.
REQ-012 SHALL have port err_valid, output, 1, one-cycle pulse per detected violation.
REQ-013 SHALL have port err_code, output, 3, code of the current violation (0 = none).
REQ-014 SHALL have port err_bank, output, BA_W, bank of the current violation.
REQ-015 SHALL have port err_sticky, output, NUM_BANKS, per-bank violation-seen flags.
REQ-016 SHALL have port err_count, output, 16, saturating total violation count.

Function
REQ-017 SHALL decode {cs_n,ras_n,cas_n,we_n} only when sdr_cke=1; cs_n=1 or cke=0 is NOP; 0011 ACT, 0101 READ, 0100 WRITE, 0010 PRE, 0001 REF, 0000 LMR, 0110 BST.
REQ-018 SHALL keep per-bank FSM IDLE, OPEN, PRECHG with 4-bit tRCD, tRAS and tRP down-counters.
REQ-019 IDLE->OPEN on ACT to that bank; tRCD counter loads TRCD-1 and tRAS counter loads TRAS-1, each decrementing to 0 and holding.
REQ-020 OPEN->PRECHG on PRE to that bank, or any PRE with addr[10]=1; tRP counter loads TRP-1.
REQ-021 PRECHG->IDLE when the tRP counter is 0 and no command targets the bank in that cycle.
REQ-022 PRE to an IDLE bank SHALL be legal with no state change.
REQ-023 SHALL raise code 1 on ACT to a bank that is not IDLE.
REQ-024 SHALL raise code 2 on READ/WRITE to a bank that is not OPEN, or OPEN with tRCD counter nonzero.
REQ-025 SHALL raise code 3 on PRE to an OPEN bank with tRAS counter nonzero.
REQ-026 SHALL raise code 4 on REF or LMR while any bank is not IDLE; err_bank is the lowest such bank.
REQ-027 SHALL raise code 5 on any non-NOP command to a bank in PRECHG.
REQ-028 Where codes collide in one cycle, SHALL report the lowest numbered code.
REQ-029 Violating commands SHALL still update bank state as in REQ-019..021, except ACT to a non-IDLE bank.
REQ-030 err_valid, err_code and err_bank SHALL be registered, one cycle after the offending command edge; err_code=0 when err_valid=0.
REQ-031 err_count SHALL saturate at 16'hFFFF; err_sticky bit sets with err_valid.
REQ-032 When err_clr and a new violation coincide, sticky and count SHALL be cleared and then reflect the new violation (count=1).

Reset
REQ-033 On sdram_resetn=0, SHALL asynchronously force all banks IDLE, all counters 0, err_valid=0, err_code=0, err_bank=0, err_sticky=0 and err_count=0; a reset mid-burst discards all history.

Configuration
REQ-034 With macro SDR_MON_TRAS_EN defined, the tRAS counter and code 3 SHALL be present; without it, the tRAS logic SHALL be removed, code 3 never asserted and PRE to OPEN always legal.

Verification
REQ-035 ACT b0, NOP x2, READ b0 (TRCD=3) -> no error; READ one cycle earlier -> err_code=2, err_bank=0.
REQ-036 ACT b1 then ACT b1 two cycles later -> err_code=1, err_bank=1, err_sticky=4'b0010, err_count=1.
REQ-037 ACT b2, PRE b2 after 3 cycles (TRAS=6) -> err_code=3 with SDR_MON_TRAS_EN, no error without it.
REQ-038 ACT b3, PRE-all, REF next cycle (TRP=3) -> err_code=4 (REF/LMR outranks code 5), err_bank=3.
REQ-039 Force 65540 violations -> err_count=16'hFFFF; err_clr with a violation in the same cycle -> err_count=1.
REQ-040 Assert sdram_resetn=0 with bank 0 OPEN -> all outputs 0 immediately; READ b0 after release -> err_code=2.
